// File: rtl/bsg_mem_1rw_arb_ctrl.sv
// bsg_mem_1rw_arb_ctrl
//
// Shares a single 1RW SRAM wrapper (one-cycle read latency) between two
// requesters with round-robin arbitration. After reset every SRAM entry is
// cleared to zero before any request is accepted. Read data is returned one
// cycle after the grant and is held locally until the consumer takes it, so
// the SRAM output only needs to be valid in the cycle after a read.
//
// Ports
//   clk_i, reset_i       clock, synchronous active-high reset
//   req_v_i/req_w_i      per-requester valid / write(1)-read(0)
//   req_addr_i           per-requester address, requester i at slice i
//   req_data_i           per-requester write data, requester i at slice i
//   req_ready_o          one-hot grant (accepted when v & ready)
//   rdata_v_o/rdata_o    read response valid / data
//   rdata_id_o           requester that issued the read
//   rdata_yumi_i         consumer takes the response
//   init_done_o          clear sequence complete
//   mem_*_o / mem_data_i connection to the SRAM wrapper
module bsg_mem_1rw_arb_ctrl #(
    parameter int width_p = 64,
    parameter int els_p = 512,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [1:0]                 req_v_i,
    input  logic [1:0]                 req_w_i,
    input  logic [2*addr_width_lp-1:0] req_addr_i,
    input  logic [2*width_p-1:0]       req_data_i,
    output logic [1:0]                 req_ready_o,
    output logic                       rdata_v_o,
    output logic [width_p-1:0]         rdata_o,
    output logic                       rdata_id_o,
    input  logic                       rdata_yumi_i,
    output logic                       init_done_o,
    output logic                       mem_v_o,
    output logic                       mem_w_o,
    output logic [addr_width_lp-1:0]   mem_addr_o,
    output logic [width_p-1:0]         mem_data_o,
    input  logic [width_p-1:0]         mem_data_i
);

    typedef enum logic {INIT = 1'b0, READY = 1'b1} state_e;

    localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

    state_e                     state_r, state_n;
    logic [addr_width_lp-1:0]   cnt_r, cnt_n;
    logic                       last_r;

    logic [1:0]                 elig;
    logic [1:0]                 gnt;
    logic                       sel;
    logic                       gnt_rd;
    logic                       resp_free;

    logic                       vld_p1;
    logic                       id_p1;
    logic                       hold_vld_r;
    logic                       hold_id_r;
    logic [width_p-1:0]         hold_r;

    // The direct path (vld_p1) and the held copy are mutually exclusive:
    // at most one read is ever in flight or parked.
    assign rdata_v_o   = vld_p1 | hold_vld_r;
    assign rdata_o     = hold_vld_r ? hold_r : mem_data_i;
    assign rdata_id_o  = hold_vld_r ? hold_id_r : id_p1;
    assign resp_free   = ~rdata_v_o | rdata_yumi_i;
    assign init_done_o = (state_r == READY);
    assign req_ready_o = gnt;

    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        elig       = 2'b00;
        gnt        = 2'b00;
        sel        = 1'b0;
        gnt_rd     = 1'b0;
        mem_v_o    = 1'b0;
        mem_w_o    = 1'b0;
        mem_addr_o = cnt_r;
        mem_data_o = '0;
        case (state_r)
            INIT: begin
                mem_v_o = 1'b1;
                mem_w_o = 1'b1;
                cnt_n   = cnt_r + addr_width_lp'(1);
                if (cnt_r == last_addr_lp) begin
                    state_n = READY;
                end
            end
            READY: begin
                // Reads wait until the response slot is free or being freed.
                elig = req_v_i & (req_w_i | {2{resp_free}});
                case (elig)
                    2'b01:   gnt = 2'b01;
                    2'b10:   gnt = 2'b10;
                    2'b11:   gnt = last_r ? 2'b01 : 2'b10;
                    default: gnt = 2'b00;
                endcase
                sel        = gnt[1];
                gnt_rd     = (|gnt) & ~req_w_i[sel];
                mem_v_o    = |gnt;
                mem_w_o    = (|gnt) & req_w_i[sel];
                mem_addr_o = sel ? req_addr_i[2*addr_width_lp-1:addr_width_lp]
                                 : req_addr_i[addr_width_lp-1:0];
                mem_data_o = sel ? req_data_i[2*width_p-1:width_p]
                                 : req_data_i[width_p-1:0];
            end
            default: state_n = INIT;
        endcase
    end

    // Stage p0 -> p1: control state and response bookkeeping
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= INIT;
            cnt_r      <= '0;
            last_r     <= 1'b1;
            vld_p1     <= 1'b0;
            hold_vld_r <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            if (|gnt) begin
                last_r <= sel;
            end
            vld_p1 <= gnt_rd;
            if (vld_p1 & ~rdata_yumi_i) begin
                hold_vld_r <= 1'b1;
            end else if (rdata_yumi_i) begin
                hold_vld_r <= 1'b0;
            end
        end
    end

    // Stage p1 -> hold: the SRAM output is only valid for one cycle, so an
    // unconsumed response is parked before a later access can disturb it.
    always_ff @(posedge clk_i) begin
        if (gnt_rd) begin
            id_p1 <= sel;
        end
        if (vld_p1 & ~rdata_yumi_i) begin
            hold_r    <= mem_data_i;
            hold_id_r <= id_p1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(rdata_yumi_i && !rdata_v_o))
                else $error("rdata_yumi_i asserted with no response pending");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_mem_1rw_arb_ctrl.sv
module tb_bsg_mem_1rw_arb_ctrl;

    localparam int W = 16;
    localparam int N = 8;
    localparam int A = 3;

    logic           clk = 1'b0;
    logic           reset_i;
    logic [1:0]     req_v, req_w;
    logic [A-1:0]   a0, a1;
    logic [W-1:0]   d0, d1;
    logic           yumi;

    logic [1:0]     req_ready;
    logic           rdata_v;
    logic [W-1:0]   rdata;
    logic           rdata_id;
    logic           init_done;
    logic           mem_v, mem_w;
    logic [A-1:0]   mem_addr;
    logic [W-1:0]   mem_wdata;
    logic [W-1:0]   mem_q;

    logic [W-1:0]   sram [N] = '{default: 16'h5A5A};

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bsg_mem_1rw_arb_ctrl #(.width_p(W), .els_p(N)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .req_v_i      (req_v),
        .req_w_i      (req_w),
        .req_addr_i   ({a1, a0}),
        .req_data_i   ({d1, d0}),
        .req_ready_o  (req_ready),
        .rdata_v_o    (rdata_v),
        .rdata_o      (rdata),
        .rdata_id_o   (rdata_id),
        .rdata_yumi_i (yumi),
        .init_done_o  (init_done),
        .mem_v_o      (mem_v),
        .mem_w_o      (mem_w),
        .mem_addr_o   (mem_addr),
        .mem_data_o   (mem_wdata),
        .mem_data_i   (mem_q)
    );

    // SRAM model: output valid only in the cycle after a read, junk otherwise.
    always @(posedge clk) begin
        if (mem_v && !mem_w) begin
            mem_q <= sram[mem_addr];
        end else begin
            mem_q <= 16'hBAD0;
        end
        if (mem_v && mem_w) begin
            sram[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    task automatic req(input logic [1:0] v, input logic [1:0] w,
                       input logic [A-1:0] x0, input logic [W-1:0] y0,
                       input logic [A-1:0] x1, input logic [W-1:0] y1);
        req_v = v; req_w = w; a0 = x0; d0 = y0; a1 = x1; d1 = y1;
    endtask

    task automatic init_window(input int k);
        #1;
        chk("init_mem_v", mem_v, 1);
        chk("init_mem_w", mem_w, 1);
        chk("init_addr", mem_addr, k);
        chk("init_data", mem_wdata, 0);
        chk("init_ready", req_ready, 2'b00);
        chk("init_done_lo", init_done, 0);
    endtask

    initial begin
        reset_i = 1'b1;
        yumi    = 1'b0;
        req(2'b00, 2'b00, 0, 0, 0, 0);

        // Reset state
        @(negedge clk); #1;
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_rdata_v", rdata_v, 0);
        chk("rst_init_done", init_done, 0);

        // Clear sequence with both requesters pushing writes
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            reset_i = 1'b0;
            req(2'b11, 2'b11, 1, 16'h7777, 2, 16'h8888);
            init_window(k);
        end
        @(negedge clk);
        req(2'b00, 2'b00, 0, 0, 0, 0);
        #1;
        chk("ready_init_done", init_done, 1);
        chk("ready_idle_ready", req_ready, 2'b00);
        chk("ready_idle_mem_v", mem_v, 0);

        // Req0 writes DEAD to 5, then reads it back with yumi held
        @(negedge clk);
        req(2'b01, 2'b01, 5, 16'hDEAD, 0, 0);
        #1;
        chk("wr5_ready", req_ready, 2'b01);
        chk("wr5_mem_w", mem_w, 1);
        chk("wr5_addr", mem_addr, 5);
        chk("wr5_data", mem_wdata, 16'hDEAD);
        @(negedge clk);
        req(2'b01, 2'b00, 5, 0, 0, 0);
        #1;
        chk("rd5_ready", req_ready, 2'b01);
        chk("rd5_mem_w", mem_w, 0);
        @(negedge clk);
        req(2'b00, 2'b00, 0, 0, 0, 0);
        yumi = 1'b1;
        #1;
        chk("rd5_v", rdata_v, 1);
        chk("rd5_data", rdata, 16'hDEAD);
        chk("rd5_id", rdata_id, 0);
        @(negedge clk);
        yumi = 1'b0;
        #1;
        chk("rd5_done_v", rdata_v, 0);

        // Req1 reads a cleared entry
        @(negedge clk);
        req(2'b10, 2'b00, 0, 0, 2, 0);
        #1;
        chk("rd2_ready", req_ready, 2'b10);
        @(negedge clk);
        req(2'b00, 2'b00, 0, 0, 0, 0);
        yumi = 1'b1;
        #1;
        chk("rd2_v", rdata_v, 1);
        chk("rd2_data", rdata, 0);
        chk("rd2_id", rdata_id, 1);
        @(negedge clk);
        yumi = 1'b0;

        // Both requesters write continuously: grants alternate 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req(2'b11, 2'b11, 0, 16'h1111, 1, 16'h2222);
            #1;
            chk("rr_grant", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
        end

        // Held read survives a write to the same address
        @(negedge clk);
        req(2'b01, 2'b01, 3, 16'h0011, 0, 0);
        #1;
        chk("wr3_ready", req_ready, 2'b01);
        @(negedge clk);
        req(2'b01, 2'b00, 3, 0, 0, 0);
        #1;
        chk("rd3_ready", req_ready, 2'b01);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req(2'b11, 2'b10, 3, 0, 3, 16'h0022);
            yumi = 1'b0;
            #1;
            chk("hold_v", rdata_v, 1);
            chk("hold_data", rdata, 16'h0011);
            chk("hold_id", rdata_id, 0);
            chk("hold_ready", req_ready, 2'b10);
        end
        @(negedge clk);
        req(2'b01, 2'b00, 3, 0, 0, 0);
        yumi = 1'b1;
        #1;
        chk("hold_yumi_data", rdata, 16'h0011);
        chk("hold_yumi_ready", req_ready, 2'b01);
        @(negedge clk);
        req(2'b00, 2'b00, 0, 0, 0, 0);
        yumi = 1'b1;
        #1;
        chk("rd3b_v", rdata_v, 1);
        chk("rd3b_data", rdata, 16'h0022);
        chk("rd3b_id", rdata_id, 0);
        @(negedge clk);
        yumi = 1'b0;
        #1;
        chk("rd3b_done_v", rdata_v, 0);

        // Back-to-back reads with yumi and new grant in the same cycle
        @(negedge clk);
        req(2'b01, 2'b00, 5, 0, 0, 0);
        #1;
        chk("b2b0_ready", req_ready, 2'b01);
        @(negedge clk);
        req(2'b10, 2'b00, 0, 0, 3, 0);
        yumi = 1'b1;
        #1;
        chk("b2b0_data", rdata, 16'hDEAD);
        chk("b2b0_id", rdata_id, 0);
        chk("b2b1_ready", req_ready, 2'b10);
        @(negedge clk);
        req(2'b01, 2'b00, 0, 0, 0, 0);
        yumi = 1'b1;
        #1;
        chk("b2b1_v", rdata_v, 1);
        chk("b2b1_data", rdata, 16'h0022);
        chk("b2b1_id", rdata_id, 1);
        chk("b2b2_ready", req_ready, 2'b01);
        @(negedge clk);
        req(2'b00, 2'b00, 0, 0, 0, 0);
        yumi = 1'b1;
        #1;
        chk("b2b2_v", rdata_v, 1);
        chk("b2b2_data", rdata, 16'h1111);
        chk("b2b2_id", rdata_id, 0);
        @(negedge clk);
        yumi = 1'b0;
        #1;
        chk("b2b_done_v", rdata_v, 0);

        // Reset from READY drops a pending response
        @(negedge clk);
        req(2'b01, 2'b00, 5, 0, 0, 0);
        #1;
        chk("pend_ready", req_ready, 2'b01);
        @(negedge clk);
        req(2'b00, 2'b00, 0, 0, 0, 0);
        reset_i = 1'b1;
        #1;
        chk("pend_v", rdata_v, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            reset_i = 1'b0;
            req(2'b11, 2'b11, 1, 16'h7777, 2, 16'h8888);
            init_window(k);
            if (k == 0) chk("pend_dropped", rdata_v, 0);
            if (k == 4) reset_i = 1'b1;
        end

        // Reset at counter 4 restarts the full clear
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            reset_i = 1'b0;
            req(2'b11, 2'b11, 1, 16'h7777, 2, 16'h8888);
            init_window(k);
        end
        @(negedge clk);
        req(2'b10, 2'b00, 0, 0, 5, 0);
        #1;
        chk("reinit_done", init_done, 1);
        chk("reinit_rd_ready", req_ready, 2'b10);
        @(negedge clk);
        req(2'b00, 2'b00, 0, 0, 0, 0);
        yumi = 1'b1;
        #1;
        chk("reinit_rd_v", rdata_v, 1);
        chk("reinit_rd_data", rdata, 0);
        chk("reinit_rd_id", rdata_id, 1);
        @(negedge clk);
        yumi = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
